// File: rtl/exp_ker_fetch_pkg.sv
// Shared definitions for the expand-3x3 kernel fetch scheduler:
// state encoding, default sizing and the word-to-byte address shift.
package exp_ker_fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_CHECK = 3'd2,
      S_REQ   = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int BURST_MAX_DEF = 16;
   localparam int FIFO_CAP_DEF  = 255;
   localparam int WORD_SHIFT    = 3;

endpackage

// File: rtl/exp_3x3_ker_fetch_sched.sv
// Fetches a kernel set from memory in bursts into the expand-3x3 FIFO,
// issuing a burst only when the FIFO can absorb it plus all data still in flight.
//
// state | meaning
// IDLE  | waiting for start_i
// CLEAR | one-cycle FIFO clear, credit counter zeroed
// CHECK | size next burst, wait for FIFO room
// REQ   | burst request held until rd_ack_i
// DRAIN | all bursts issued, waiting for outstanding beats
// DONE  | one-cycle completion, done_o follows
module exp_3x3_ker_fetch_sched
   import exp_ker_fetch_pkg::*;
#(
   parameter int BURST_MAX = BURST_MAX_DEF,
   parameter int FIFO_CAP  = FIFO_CAP_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] ker_base_addr_i,
   input  logic [15:0] ker_word_total_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        ovf_err_o,
   output logic        rd_req_o,
   output logic [31:0] rd_addr_o,
   output logic [4:0]  rd_len_o,
   input  logic        rd_ack_i,
   input  logic [63:0] rd_data_i,
   input  logic        rd_valid_i,
   output logic        fifo_exp_3x3_clr_o,
   output logic [63:0] fifo_exp_3x3_wr_data_o,
   output logic        fifo_exp_3x3_wr_en_o,
   input  logic [7:0]  fifo_exp_3x3_data_count_i
);

   localparam logic [4:0]  BURST_LEN = 5'(BURST_MAX);
   localparam logic [15:0] BURST_REM = 16'(BURST_MAX);
   localparam logic [9:0]  CAP       = 10'(FIFO_CAP);

   state_t      state;
   logic [31:0] addr;
   logic [15:0] remaining;
   logic [8:0]  outstanding;

   logic [4:0]  len;
   logic [9:0]  credit_sum;
   logic        fits;
   logic        ack_take;
   logic        beat_ok;
   logic        start_take;

   always_comb begin
      len        = (remaining >= BURST_REM) ? BURST_LEN : remaining[4:0];
      credit_sum = {2'b00, fifo_exp_3x3_data_count_i} + {1'b0, outstanding} + {5'b0, len};
      fits       = (credit_sum <= CAP);
      ack_take   = (state == S_REQ) && rd_ack_i;
      beat_ok    = rd_valid_i && (outstanding != 9'd0);
      start_take = (state == S_IDLE) && start_i;
   end

   // Beats arriving with no credit are still forwarded but flagged, never underflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outstanding <= 9'd0;
      end else if (state == S_CLEAR) begin
         outstanding <= 9'd0;
      end else begin
         outstanding <= outstanding + (ack_take ? {4'b0, rd_len_o} : 9'd0) - {8'b0, beat_ok};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_err_o <= 1'b0;
      end else if (rd_valid_i && (outstanding == 9'd0)) begin
         ovf_err_o <= 1'b1;
      end else if (start_take) begin
         ovf_err_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fifo_exp_3x3_wr_en_o   <= 1'b0;
         fifo_exp_3x3_wr_data_o <= 64'd0;
      end else begin
         fifo_exp_3x3_wr_en_o <= rd_valid_i;
         if (rd_valid_i) fifo_exp_3x3_wr_data_o <= rd_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state              <= S_IDLE;
         addr               <= 32'd0;
         remaining          <= 16'd0;
         busy_o             <= 1'b0;
         done_o             <= 1'b0;
         fifo_exp_3x3_clr_o <= 1'b0;
         rd_req_o           <= 1'b0;
         rd_addr_o          <= 32'd0;
         rd_len_o           <= 5'd0;
      end else begin
         done_o             <= 1'b0;
         fifo_exp_3x3_clr_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  busy_o <= 1'b1;
                  if (ker_word_total_i != 16'd0) begin
                     addr               <= ker_base_addr_i;
                     remaining          <= ker_word_total_i;
                     fifo_exp_3x3_clr_o <= 1'b1;
                     state              <= S_CLEAR;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_CLEAR: state <= S_CHECK;
            S_CHECK: begin
               if (remaining == 16'd0) begin
                  state <= S_DRAIN;
               end else if (fits) begin
                  rd_req_o  <= 1'b1;
                  rd_addr_o <= addr;
                  rd_len_o  <= len;
                  state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (rd_ack_i) begin
                  rd_req_o  <= 1'b0;
                  addr      <= addr + ({27'd0, rd_len_o} << WORD_SHIFT);
                  remaining <= remaining - {11'd0, rd_len_o};
                  state     <= S_CHECK;
               end
            end
            S_DRAIN: begin
               if (outstanding == 9'd0) state <= S_DONE;
            end
            S_DONE: begin
               done_o <= 1'b1;
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_o   <= 1'b0;
               rd_req_o <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exp_3x3_ker_fetch_sched.sv
// Scoreboard bench: a memory responder issues acks and beats, expected bursts and
// FIFO writes are queued from a reference model and checked by independent monitors.
module tb_exp_3x3_ker_fetch_sched;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] ker_base_addr_i;
   logic [15:0] ker_word_total_i;
   logic        busy_o, done_o, ovf_err_o, rd_req_o;
   logic [31:0] rd_addr_o;
   logic [4:0]  rd_len_o;
   logic        rd_ack_i;
   logic [63:0] rd_data_i;
   logic        rd_valid_i;
   logic        fifo_clr, fifo_wr_en;
   logic [63:0] fifo_wr_data;
   logic [7:0]  dc;

   exp_3x3_ker_fetch_sched dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .ker_base_addr_i(ker_base_addr_i), .ker_word_total_i(ker_word_total_i),
      .busy_o(busy_o), .done_o(done_o), .ovf_err_o(ovf_err_o),
      .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_len_o(rd_len_o),
      .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i),
      .fifo_exp_3x3_clr_o(fifo_clr), .fifo_exp_3x3_wr_data_o(fifo_wr_data),
      .fifo_exp_3x3_wr_en_o(fifo_wr_en), .fifo_exp_3x3_data_count_i(dc)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   logic [63:0] exp_wr[$];
   logic [31:0] exp_addr[$];
   int          exp_len[$];

   int pend = 0;
   int ack_dmax = 0;
   bit ack_fixed = 1'b1;
   int vprob = 100;
   int hold_at = 0;
   bit inject = 1'b0;
   int n_wr = 0, n_clr = 0, n_req_cyc = 0, n_burst = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference: split the total into maximal bursts of 16 words at consecutive addresses.
   task automatic model_bursts(input logic [31:0] base, input int total);
      int rem = total;
      logic [31:0] a = base;
      while (rem > 0) begin
         int l = (rem < 16) ? rem : 16;
         exp_addr.push_back(a);
         exp_len.push_back(l);
         a   = a + 32'(l * 8);
         rem = rem - l;
      end
   endtask

   // Memory responder: acks requests after a delay, returns beats for acked bursts.
   initial begin : mem
      bit in_req = 1'b0;
      int wait_c = 0;
      int add_len;
      logic [31:0] cap_a;
      logic [4:0]  cap_l;
      rd_ack_i = 1'b0; rd_valid_i = 1'b0; rd_data_i = 64'd0;
      forever begin
         @(negedge clk_i);
         rd_ack_i = 1'b0; rd_valid_i = 1'b0; add_len = 0;
         if (rst_i) begin
            in_req = 1'b0;
            continue;
         end
         if (rd_req_o) begin
            if (!in_req) begin
               in_req = 1'b1; cap_a = rd_addr_o; cap_l = rd_len_o;
               wait_c = ack_fixed ? ack_dmax : int'($urandom_range(ack_dmax, 0));
            end else begin
               chk("req_addr_stable", rd_addr_o, cap_a);
               chk("req_len_stable", rd_len_o, cap_l);
            end
            if (wait_c == 0) begin
               chk("burst_expected", exp_addr.size() != 0, 1);
               if (exp_addr.size() != 0) begin
                  chk("burst_addr", rd_addr_o, exp_addr.pop_front());
                  chk("burst_len", rd_len_o, exp_len.pop_front());
               end
               chk("credit_room", (int'(dc) + pend + int'(rd_len_o)) <= 255, 1);
               add_len = int'(rd_len_o);
               rd_ack_i = 1'b1; in_req = 1'b0; n_burst++;
            end else begin
               wait_c--;
            end
         end
         if (inject) begin
            rd_valid_i = 1'b1; rd_data_i = {$urandom, $urandom};
            exp_wr.push_back(rd_data_i); inject = 1'b0;
         end else if (pend > hold_at && int'($urandom_range(99, 0)) < vprob) begin
            rd_valid_i = 1'b1; rd_data_i = {$urandom, $urandom};
            exp_wr.push_back(rd_data_i); pend--;
         end
         pend += add_len;
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk_i);
         if (fifo_wr_en) begin
            n_wr++;
            chk("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) chk("wr_data", fifo_wr_data, exp_wr.pop_front());
         end
         if (fifo_clr) n_clr++;
         if (rd_req_o) n_req_cyc++;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   task automatic do_start(input logic [31:0] base, input int total);
      @(negedge clk_i);
      ker_base_addr_i = base; ker_word_total_i = 16'(total); start_i = 1'b1;
      model_bursts(base, total);
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic finish_txn(input int total, input int wr0);
      for (int k = 0; k < 3000 && !done_o; k++) @(negedge clk_i);
      chk("done_seen", done_o, 1);
      chk("busy_at_done", busy_o, 0);
      @(negedge clk_i); #1;
      chk("write_count", n_wr - wr0, total);
      chk("bursts_left", exp_addr.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
      chk("ovf_clear", ovf_err_o, 0);
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk({nm, "_busy"}, busy_o, 0);
      chk({nm, "_done"}, done_o, 0);
      chk({nm, "_ovf"}, ovf_err_o, 0);
      chk({nm, "_req"}, rd_req_o, 0);
      chk({nm, "_addr"}, rd_addr_o, 0);
      chk({nm, "_len"}, rd_len_o, 0);
      chk({nm, "_clr"}, fifo_clr, 0);
      chk({nm, "_wr_en"}, fifo_wr_en, 0);
      chk({nm, "_wr_data"}, fifo_wr_data, 0);
   endtask

   initial begin : main
      int wr0, b0, c0, r0;
      bit seen;
      rst_i = 1'b1; start_i = 1'b0; ker_base_addr_i = 32'd0; ker_word_total_i = 16'd0; dc = 8'd0;
      #1;
      chk_outputs_zero("reset");
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("no_req_after_reset", rd_req_o, 0);

      // 40 words from 0x1000, immediate ack
      wr0 = n_wr; b0 = n_burst; c0 = n_clr;
      do_start(32'h1000, 40);
      chk("busy_after_start", busy_o, 1);
      finish_txn(40, wr0);
      chk("t1_bursts", n_burst - b0, 3);
      chk("t1_clr", n_clr - c0, 1);

      // zero-length fetch
      r0 = n_req_cyc; c0 = n_clr;
      @(negedge clk_i);
      ker_word_total_i = 16'd0; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("zero_done_early", done_o, 0);
      @(negedge clk_i);
      chk("zero_done", done_o, 1);
      @(negedge clk_i); #1;
      chk("zero_no_req", n_req_cyc - r0, 0);
      chk("zero_no_clr", n_clr - c0, 0);

      // FIFO nearly full holds off the request until one word of room appears
      dc = 8'd240; wr0 = n_wr; r0 = n_req_cyc;
      do_start(32'h2000, 16);
      repeat (12) @(negedge clk_i);
      #1;
      chk("stall_no_req", n_req_cyc - r0, 0);
      chk("stall_busy", busy_o, 1);
      dc = 8'd239;
      seen = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         seen |= rd_req_o;
      end
      chk("req_after_room", seen, 1);
      finish_txn(16, wr0);
      dc = 8'd0;

      // ack delayed by 5 cycles
      ack_dmax = 5; wr0 = n_wr; b0 = n_burst; r0 = n_req_cyc;
      do_start(32'h3000, 16);
      finish_txn(16, wr0);
      chk("slow_ack_bursts", n_burst - b0, 1);
      chk("slow_ack_req_cycles", n_req_cyc - r0, 6);
      ack_dmax = 0;

      // beat with no credit while idle
      wr0 = n_wr;
      inject = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      chk("ovf_set", ovf_err_o, 1);
      chk("ovf_forwarded", n_wr - wr0, 1);
      wr0 = n_wr;
      do_start(32'h4000, 8);
      chk("ovf_cleared_by_start", ovf_err_o, 0);
      finish_txn(8, wr0);

      // reset with 10 words still in flight
      hold_at = 10;
      do_start(32'h5000, 16);
      for (int k = 0; k < 200 && pend != 10; k++) @(negedge clk_i);
      repeat (2) @(negedge clk_i);
      chk("pend_before_reset", pend, 10);
      rst_i = 1'b1;
      #1;
      chk_outputs_zero("mid_reset");
      exp_wr.delete(); exp_addr.delete(); exp_len.delete();
      pend = 0; hold_at = 0;
      @(negedge clk_i);
      chk("reset_idle", busy_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("reset_release_no_req", rd_req_o, 0);
      wr0 = n_wr;
      do_start(32'h6000, 24);
      finish_txn(24, wr0);

      // randomized fetches
      for (int t = 0; t < 10; t++) begin
         logic [31:0] base;
         int total;
         base      = $urandom & 32'hFFFF_FFF8;
         total     = int'($urandom_range(60, 0));
         dc        = 8'($urandom_range(239, 0));
         ack_fixed = 1'b0;
         ack_dmax  = int'($urandom_range(3, 0));
         vprob     = int'($urandom_range(100, 30));
         wr0 = n_wr;
         do_start(base, total);
         finish_txn(total, wr0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exp_3x3_ker_fetch_sched.md
EXP_3X3_KER_FETCH_SCHED -- requirements
Module: exp_3x3_ker_fetch_sched

Interface
REQ-001 SHALL have parameter BURST_MAX, default 16, meaning the maximum number of 64-bit words per memory read burst.
REQ-002 SHALL have parameter FIFO_CAP, default 255, meaning the usable word capacity of the expand-3x3 kernel FIFO.
REQ-003 SHALL use one clock, clk_i; reset SHALL be asynchronous and active-high, port rst_i.
REQ-004 clk_i  in  1  system clock.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 start_i  in  1  single-cycle pulse that begins a kernel-set fetch.
REQ-007 ker_base_addr_i  in  32  byte address of the first kernel word; bits [2:0] are zero.
REQ-008 ker_word_total_i  in  16  number of 64-bit words to fetch; 0 is legal.
REQ-009 busy_o  out  1  high from the accepted start_i until done_o.
REQ-010 done_o  out  1  single-cycle pulse when the fetch is complete.
REQ-011 ovf_err_o  out  1  sticky flag for read data received with no outstanding credit.
REQ-012 rd_req_o  out  1  burst read request.
REQ-013 rd_addr_o  out  32  burst byte address.
REQ-014 rd_len_o  out  5  burst length in words, range 1..BURST_MAX.
REQ-015 rd_ack_i  in  1  request accepted this cycle.
REQ-016 rd_data_i  in  64  returned read data.
REQ-017 rd_valid_i  in  1  rd_data_i is valid.
REQ-018 fifo_exp_3x3_clr_o  out  1  FIFO clear pulse.
REQ-019 fifo_exp_3x3_wr_data_o  out  64  FIFO write data.
REQ-020 fifo_exp_3x3_wr_en_o  out  1  FIFO write enable.
REQ-021 fifo_exp_3x3_data_count_i  in  8  current FIFO occupancy in words.

Function
REQ-022 The FSM SHALL have states IDLE, CLEAR, CHECK, REQ, DRAIN and DONE.
REQ-023 In IDLE, start_i with ker_word_total_i!=0 SHALL latch the address and total and go to CLEAR; start_i with a total of 0 SHALL go directly to DONE.
REQ-024 CLEAR SHALL assert fifo_exp_3x3_clr_o for exactly one cycle, zero the credit counter, and go to CHECK.
REQ-025 In CHECK, len SHALL be min(BURST_MAX, remaining).
REQ-026 CHECK SHALL go to DRAIN if remaining==0.
REQ-027 Otherwise CHECK SHALL go to REQ when data_count + outstanding + len <= FIFO_CAP, and SHALL stay in CHECK otherwise; the sum SHALL be computed at 10 bits with no truncation.
REQ-028 In REQ, rd_req_o SHALL be held high with rd_addr_o and rd_len_o stable until rd_ack_i.
REQ-029 On rd_ack_i in REQ: address += len*8, remaining -= len, outstanding += len, then go to CHECK.
REQ-030 DRAIN SHALL wait until outstanding==0, then go to DONE.
REQ-031 DONE SHALL pulse done_o for one cycle, then go to IDLE.
REQ-032 busy_o SHALL be high in every state except IDLE.
REQ-033 outstanding SHALL be 9 bits; each rd_valid_i SHALL decrement it by 1.
REQ-034 A simultaneous rd_ack_i and rd_valid_i SHALL apply the net change of len-1.
REQ-035 rd_valid_i with outstanding==0, in any state, SHALL set ovf_err_o, SHALL NOT decrement outstanding, and SHALL still forward the data.
REQ-036 Every rd_valid_i beat SHALL produce fifo_exp_3x3_wr_en_o one cycle later with registered data; there are no bubbles and no backpressure.
REQ-037 start_i SHALL be ignored while busy_o is high.
REQ-038 ovf_err_o SHALL clear only on reset or on an accepted start_i.

Reset
REQ-039 rst_i SHALL force state to IDLE and clear all counters and flags, asynchronously, mid-operation included.
REQ-040 Under reset all outputs SHALL be 0, including rd_addr_o, rd_len_o and the FIFO write data.
REQ-041 No request SHALL be issued in the first cycle after reset deassertion.

Structure
REQ-042 Package exp_ker_fetch_pkg SHALL hold the state encoding, BURST_MAX, FIFO_CAP and the word-to-byte shift constant 3.
REQ-043 The design SHALL be a single module with no sub-module.
REQ-044 The credit counter and the write-forward register SHALL be inline.

Verification
REQ-045 base=0x1000, total=40, FIFO empty, ack immediate -> bursts (0x1000,16), (0x1080,16), (0x1100,8); done_o after 40 valid beats; 40 FIFO writes.
REQ-046 total=0 start -> done_o two cycles after start_i; no rd_req_o; no clr pulse.
REQ-047 data_count held at 240, total=16 -> rd_req_o stays low; when data_count drops to 239 -> request issued within 2 cycles.
REQ-048 rd_ack_i delayed 5 cycles -> rd_addr_o and rd_len_o stable all 5 cycles; exactly one burst counted.
REQ-049 Inject rd_valid_i in IDLE -> ovf_err_o=1 and one FIFO write; next start_i clears ovf_err_o.
REQ-050 Assert rst_i mid-burst with outstanding=10 -> next cycle all outputs 0, state IDLE; a following start_i fetches normally.
